regfile_alu: RTL and testbench
==============================

REGFILE_ALU -- requirements
Module: regfile_alu

Interface
REQ-001 Parameter DW, default 16: data width in bits; register contents and results are signed two's complement.
REQ-002 Parameter AW, default 5: register address width; register count NREG = 2**AW.
REQ-003 Parameter ALU_LAT, default 2, legal range 1..15: number of cycles spent in EXEC for ALU ops.
REQ-004 Parameter SAT, default 0: 1 = ADD/SUB saturate on overflow, 0 = wrap.
REQ-005 Parameter ZERO_R0, default 0: 1 = register 0 always reads 0 and ignores writes.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  command request; accepted only when ready=1.
REQ-009 op  input  3  000 WRITE, 001 READ1, 010 READ2, 011 READ1_WRITE, 100 READ2_WRITE, 101 ADD, 110 SUB, 111 SHL.
REQ-010 ra, rb  input  AW each  read addresses A and B.
REQ-011 w  input  AW  write/destination address.
REQ-012 wd  input  DW  write data (WRITE, *_WRITE ops) or shift amount (SHL).
REQ-013 ready  output  1  high only in IDLE.
REQ-014 rda, rdb  output  DW each  read/result data; registered; hold until updated.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 ovf  output  1  overflow flag of the last completed command; registered; held.

Function
REQ-017 FSM states: IDLE, READ, EXEC, DONE; ready = (state==IDLE).
REQ-018 Accept edge E0 (start=1, state IDLE): latch op, ra, rb, w, wd; go to READ. start while not IDLE is ignored; inputs may change after E0 without effect.
REQ-019 Edge E1 (READ): rda <= file[ra] for ops 001-111, except WRITE, where rda <= wd.
REQ-020 E1: rdb <= file[rb] for ops 010, 100, 101, 110; rdb unchanged otherwise.
REQ-021 E1: file[w] <= wd for ops 000, 011, 100; reads at E1 return the pre-write value when ra/rb equals w.
REQ-022 E1 transitions: ops 000-100 go to DONE with ovf <= 0; ops 101-111 go to EXEC.
REQ-023 EXEC lasts exactly ALU_LAT cycles via a cycle counter. At its last edge E(1+ALU_LAT): file[w] <= result, rda <= result, ovf updated, go to DONE.
REQ-024 ADD: rda+rdb; SUB: rda-rdb; both DW-bit. ovf = signed overflow. SAT=1 on overflow: result clamps to +max (positive overflow) or -min (negative overflow).
REQ-025 SHL: rda shifted left by unsigned wd, zero fill. wd >= DW gives result 0. ovf = 1 if any nonzero bit is shifted out. SAT has no effect on SHL.
REQ-026 done = 1 exactly in the DONE state (one cycle); the next edge returns to IDLE. Back-to-back: a new command is accepted on the first IDLE cycle.
REQ-027 Latency, accept edge to done high: 1 cycle for ops 000-100; 1+ALU_LAT cycles for ops 101-111.
REQ-028 ZERO_R0=1: any read of address 0 yields 0; any write to address 0 is discarded. Results still appear on rda.

Reset
REQ-029 rst_n low, at any time including mid-operation: state IDLE, all registers 0, rda=rdb=0, done=0, ovf=0, counter 0. An in-flight command is aborted with no register write.
REQ-030 ready is high during reset and in the first cycle after rst_n deasserts.

Verification
REQ-031 Reset, WRITE w=1 wd=17, then READ1 ra=1 -> done 1 cycle after each accept, rda=17 both times, ovf=0.
REQ-032 READ1_WRITE ra=1 w=2 wd=-9, then READ2 ra=2 rb=3 after WRITE r3=65 -> first rda=17; then rda=-9, rdb=65.
REQ-033 ADD ra=1 rb=2 w=4 (ALU_LAT=2) -> done 3 cycles after accept, rda=8, r4=8, ovf=0. Then SUB of r4 from r3 into r6 -> rda=57.
REQ-034 r1=32767, r2=1, ADD -> SAT=0: rda=-32768, ovf=1. SAT=1: rda=32767, ovf=1.
REQ-035 SHL ra=3 (65) wd=3 -> rda=520, ovf=0. wd=16 -> rda=0, ovf=1. start pulsed during EXEC -> ignored, exactly one done.
REQ-036 rst_n low during EXEC of ADD w=7 -> outputs 0 asynchronously, r7 stays 0, ready=1. With ZERO_R0=1: WRITE r0=5, then READ1 r0 -> rda=0.

Source files
------------

// File: rtl/regfile_alu.sv
// Register file with a small command sequencer and a multi-cycle ALU (ADD/SUB/SHL).
// Each command is latched at accept; reads, writes and results are then sequenced by the FSM.
//
// state | meaning
// IDLE  | ready for a command, ready=1
// READ  | operand read and immediate writes; decides DONE or EXEC
// EXEC  | ALU busy for ALU_LAT cycles (down-counter to zero)
// DONE  | one-cycle completion pulse
module regfile_alu #(
    parameter int DW      = 16,
    parameter int AW      = 5,
    parameter int ALU_LAT = 2,
    parameter int SAT     = 0,
    parameter int ZERO_R0 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] w,
    input  logic [DW-1:0] wd,
    output logic          ready,
    output logic [DW-1:0] rda,
    output logic [DW-1:0] rdb,
    output logic          done,
    output logic          ovf
);

    localparam int NREG = 2**AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_WRITE  = 3'b000;
    localparam logic [2:0] OP_READ2  = 3'b010;
    localparam logic [2:0] OP_R1W    = 3'b011;
    localparam logic [2:0] OP_R2W    = 3'b100;
    localparam logic [2:0] OP_ADD    = 3'b101;
    localparam logic [2:0] OP_SUB    = 3'b110;

    localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] DW_V  = DW'(DW);

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] ra_q, ra_d, rb_q, rb_d, w_q, w_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] rda_q, rda_d, rdb_q, rdb_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] file_q [NREG];
    logic [DW-1:0] file_d [NREG];

    logic [DW-1:0]   rd_a, rd_b;
    logic            w_ok;
    logic [DW-1:0]   alu_res;
    logic            alu_ovf;
    logic [DW-1:0]   sum, diff;
    logic [2*DW-1:0] shl_wide;

    assign rd_a = (ZERO_R0 != 0 && ra_q == '0) ? '0 : file_q[ra_q];
    assign rd_b = (ZERO_R0 != 0 && rb_q == '0) ? '0 : file_q[rb_q];
    assign w_ok = !(ZERO_R0 != 0 && w_q == '0);

    assign sum  = rda_q + rdb_q;
    assign diff = rda_q - rdb_q;

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        shl_wide = {{DW{1'b0}}, rda_q} << wd_q;
        case (op_q)
            OP_ADD: begin
                alu_ovf = (rda_q[DW-1] == rdb_q[DW-1]) && (sum[DW-1] != rda_q[DW-1]);
                alu_res = sum;
                if (SAT != 0 && alu_ovf) alu_res = rda_q[DW-1] ? MIN_V : MAX_V;
            end
            OP_SUB: begin
                alu_ovf = (rda_q[DW-1] != rdb_q[DW-1]) && (diff[DW-1] != rda_q[DW-1]);
                alu_res = diff;
                if (SAT != 0 && alu_ovf) alu_res = rda_q[DW-1] ? MIN_V : MAX_V;
            end
            default: begin
                // Shift amounts >= DW push every bit out, so any nonzero operand overflows.
                if (wd_q >= DW_V) begin
                    alu_res = '0;
                    alu_ovf = |rda_q;
                end else begin
                    alu_res = shl_wide[DW-1:0];
                    alu_ovf = |shl_wide[2*DW-1:DW];
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        w_d     = w_q;
        wd_d    = wd_q;
        rda_d   = rda_q;
        rdb_d   = rdb_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        file_d  = file_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    ra_d    = ra;
                    rb_d    = rb;
                    w_d     = w;
                    wd_d    = wd;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rda_d = (op_q == OP_WRITE) ? wd_q : rd_a;
                if (op_q == OP_READ2 || op_q == OP_R2W || op_q == OP_ADD || op_q == OP_SUB)
                    rdb_d = rd_b;
                // Reads above use file_q, so same-address reads see the pre-write value.
                if ((op_q == OP_WRITE || op_q == OP_R1W || op_q == OP_R2W) && w_ok)
                    file_d[w_q] = wd_q;
                if (op_q >= OP_ADD) begin
                    cnt_d   = 4'(ALU_LAT - 1);
                    state_d = S_EXEC;
                end else begin
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    if (w_ok) file_d[w_q] = alu_res;
                    rda_d   = alu_res;
                    ovf_d   = alu_ovf;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            w_q     <= '0;
            wd_q    <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            file_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            w_q     <= w_d;
            wd_q    <= wd_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            file_q  <= file_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign rda   = rda_q;
    assign rdb   = rdb_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_regfile_alu.sv
// Bench for regfile_alu: two instances (wrap/plain r0 and saturating/zero r0) driven in lockstep,
// directed steps followed by random commands, all checked against an arithmetic reference model.
module tb_regfile_alu;
    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int LAT = 2;
    localparam int NR  = 2**AW;
    localparam logic [DW-1:0] MAXV = 16'h7FFF;
    localparam logic [DW-1:0] MINV = 16'h8000;

    localparam logic [2:0] WR = 3'd0, RD1 = 3'd1, RD2 = 3'd2, R1W = 3'd3, R2W = 3'd4,
                           ADD = 3'd5, SUB = 3'd6, SHL = 3'd7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [AW-1:0] ra = '0, rb = '0, w = '0;
    logic [DW-1:0] wd = '0;
    logic          ready0, done0, ovf0, ready1, done1, ovf1;
    logic [DW-1:0] rda0, rdb0, rda1, rdb1;

    always #5 clk = ~clk;

    regfile_alu #(.DW(DW), .AW(AW), .ALU_LAT(LAT), .SAT(0), .ZERO_R0(0)) u_plain (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ra(ra), .rb(rb), .w(w), .wd(wd),
        .ready(ready0), .rda(rda0), .rdb(rdb0), .done(done0), .ovf(ovf0));

    regfile_alu #(.DW(DW), .AW(AW), .ALU_LAT(LAT), .SAT(1), .ZERO_R0(1)) u_satz (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ra(ra), .rb(rb), .w(w), .wd(wd),
        .ready(ready1), .rda(rda1), .rdb(rdb1), .done(done1), .ovf(ovf1));

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Reference state, index 0 = plain instance, 1 = saturating / zero-r0 instance.
    logic [DW-1:0] mf [2][NR];
    logic [DW-1:0] mrda [2];
    logic [DW-1:0] mrdb [2];
    logic          movf [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < NR; i++) mf[v][i] = '0;
            mrda[v] = '0;
            mrdb[v] = '0;
            movf[v] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] mrd(input int v, input logic [AW-1:0] a);
        return (v == 1 && a == '0) ? '0 : mf[v][a];
    endfunction

    task automatic mwr(input int v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!(v == 1 && a == '0)) mf[v][a] = d;
    endtask

    task automatic model(input logic [2:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] wa, input logic [DW-1:0] d);
        for (int v = 0; v < 2; v++) begin
            logic [DW-1:0] x, y, res;
            int            sx, sy, s;
            longint        p;
            x = mrd(v, a);
            y = mrd(v, b);
            case (o)
                WR:  begin mrda[v] = d; mwr(v, wa, d); movf[v] = 1'b0; end
                RD1: begin mrda[v] = x; movf[v] = 1'b0; end
                RD2: begin mrda[v] = x; mrdb[v] = y; movf[v] = 1'b0; end
                R1W: begin mrda[v] = x; mwr(v, wa, d); movf[v] = 1'b0; end
                R2W: begin mrda[v] = x; mrdb[v] = y; mwr(v, wa, d); movf[v] = 1'b0; end
                ADD, SUB: begin
                    sx = $signed(x);
                    sy = $signed(y);
                    s  = (o == ADD) ? sx + sy : sx - sy;
                    movf[v] = (s > 32767) || (s < -32768);
                    res = s[DW-1:0];
                    if (v == 1 && movf[v]) res = (s > 0) ? MAXV : MINV;
                    mrdb[v] = y;
                    mrda[v] = res;
                    mwr(v, wa, res);
                end
                default: begin
                    if (d >= 16'(DW)) begin
                        res = '0;
                        movf[v] = (x != '0);
                    end else begin
                        p = longint'(x) << d;
                        res = p[DW-1:0];
                        movf[v] = ((p >> DW) != 0);
                    end
                    mrda[v] = res;
                    mwr(v, wa, res);
                end
            endcase
        end
    endtask

    task automatic cmd(input logic [2:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [AW-1:0] wa, input logic [DW-1:0] d, input bit poke);
        int n;
        int exp_lat;
        @(negedge clk);
        check("ready_before_accept_plain", ready0, 1);
        check("ready_before_accept_satz", ready1, 1);
        start = 1'b1; op = o; ra = a; rb = b; w = wa; wd = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'($urandom); ra = AW'($urandom); rb = AW'($urandom);
        w = AW'($urandom); wd = DW'($urandom);
        model(o, a, b, wa, d);
        n = 0;
        while (!done0 && n < 40) begin
            start = poke && (n == 1);
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        exp_lat = (o >= ADD) ? 1 + LAT : 1;
        check("latency", n, exp_lat);
        check("done_satz", done1, 1);
        check("rda_plain", rda0, mrda[0]);
        check("rdb_plain", rdb0, mrdb[0]);
        check("ovf_plain", ovf0, movf[0]);
        check("rda_satz", rda1, mrda[1]);
        check("rdb_satz", rdb1, mrdb[1]);
        check("ovf_satz", ovf1, movf[1]);
        @(posedge clk);
        #1;
        check("done_one_cycle", done0, 0);
        check("ready_after_done", ready0, 1);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            check("poke_ignored_ready", ready0, 1);
            check("poke_ignored_done", done0, 0);
        end
    endtask

    initial begin
        logic [2:0]    ro;
        logic [DW-1:0] rd;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready0, 1);
        check("rst_done", done0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_rda", rda0, 0);
        check("rst_rdb", rdb1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_cycle", ready0, 1);

        cmd(WR,  0, 0, 1, 16'd17, 0);
        cmd(RD1, 1, 0, 0, 16'd0, 0);
        cmd(R1W, 1, 0, 2, 16'hFFF7, 0);
        cmd(WR,  0, 0, 3, 16'd65, 0);
        cmd(RD2, 2, 3, 0, 16'd0, 0);
        cmd(ADD, 1, 2, 4, 16'd0, 0);
        cmd(SUB, 3, 4, 6, 16'd0, 0);
        cmd(R2W, 3, 3, 3, 16'd100, 0);
        cmd(WR,  0, 0, 3, 16'd65, 0);
        cmd(WR,  0, 0, 1, 16'd32767, 0);
        cmd(WR,  0, 0, 2, 16'd1, 0);
        cmd(ADD, 1, 2, 5, 16'd0, 0);
        cmd(WR,  0, 0, 10, 16'h8000, 0);
        cmd(SUB, 10, 2, 11, 16'd0, 0);
        cmd(SHL, 3, 0, 8, 16'd3, 0);
        cmd(SHL, 3, 0, 9, 16'd16, 1);
        cmd(SHL, 10, 0, 12, 16'd0, 0);
        cmd(SHL, 3, 0, 13, 16'd10, 0);
        cmd(WR,  0, 0, 0, 16'd5, 0);
        cmd(RD1, 0, 0, 0, 16'd0, 0);

        // Abort an ADD in EXEC with an asynchronous reset between clock edges.
        @(negedge clk);
        start = 1'b1; op = ADD; ra = 1; rb = 2; w = 7; wd = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_rda", rda0, 0);
        check("async_rst_rdb", rdb0, 0);
        check("async_rst_ovf", ovf1, 0);
        check("async_rst_done", done0, 0);
        check("async_rst_ready", ready0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_release", ready1, 1);
        cmd(RD2, 7, 1, 0, 16'd0, 0);

        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rd = DW'($urandom);
                1: rd = DW'($urandom_range(0, 300));
                2: rd = MAXV - DW'($urandom_range(0, 3));
                default: rd = MINV + DW'($urandom_range(0, 3));
            endcase
            if (ro == SHL) rd = DW'($urandom_range(0, 20));
            cmd(ro, AW'($urandom), AW'($urandom), AW'($urandom_range(0, 7)), rd, 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
